pipe_hazard_ctrl: RTL and testbench

Parametrised, stateful successor of the pipeline hazard/redirect controller in the 5-stage CPU. It produces per-register stall and flush vectors, a PC-source select and a redirect vector from branch, jump, jr, load-use, memory-stall and exception inputs. It sits beside the pipeline registers and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB. New over the previous generation:
- configurable load-use latency
- separate interrupt and exception vectors
- exceptions that arrive during a memory stall are held and taken later, not dropped
- optional stall watchdog

---
 rtl/cpu_ctrl_pkg.sv | 44 ++++
 rtl/exc_vector_map.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: PC source codes, exception codes,
// stall/flush bit positions and the hazard controller state encoding.
package cpu_ctrl_pkg;

    // PC source select codes
    localparam logic [2:0] PC_JMP  = 3'd0;
    localparam logic [2:0] PC_EXC  = 3'd1;
    localparam logic [2:0] PC_ERET = 3'd2;
    localparam logic [2:0] PC_CTRL = 3'd3;
    localparam logic [2:0] PC_SEQ  = 3'd4;

    // Exception codes as presented by the MEM stage
    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT0    = 32'h1;
    localparam logic [31:0] EXC_INT7    = 32'h8;
    localparam logic [31:0] EXC_SYSCALL = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'hA;
    localparam logic [31:0] EXC_OV      = 32'hB;
    localparam logic [31:0] EXC_TR      = 32'hC;
    localparam logic [31:0] EXC_ERET    = 32'hD;

    // Stall/flush vector bit positions
    localparam int B_PC    = 0;
    localparam int B_IFID  = 1;
    localparam int B_IDEX  = 2;
    localparam int B_EXMEM = 3;
    localparam int B_MEMWB = 4;

    // Common stall/flush patterns
    localparam logic [4:0] SF_NONE     = 5'b00000;
    localparam logic [4:0] STALL_ALL   = 5'b11111;
    localparam logic [4:0] STALL_LU    = 5'b00011;
    localparam logic [4:0] FLUSH_LU    = 5'b00100;
    localparam logic [4:0] FLUSH_BR    = 5'b00110;
    localparam logic [4:0] FLUSH_EXC   = 5'b01110;
    localparam logic [4:0] FLUSH_WDOG  = 5'b11110;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        LU   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/exc_vector_map.sv
// Combinational map from an exception code to its PC source, redirect
// vector and reserved-instruction flag. Shared with the CP0 block.
module exc_vector_map
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN    = 32,
    parameter logic [XLEN-1:0]  VEC_EXC = 32'h80000000,
    parameter logic [XLEN-1:0]  VEC_INT = 32'h80000180
) (
    input  logic [31:0]     code,
    output logic [2:0]      pc_src,
    output logic [XLEN-1:0] vector,
    output logic            ri_flag
);

    // Interrupts go to the interrupt vector, eret has no vector, and every
    // other code (including unknown ones) goes to the general vector.
    always_comb begin
        pc_src  = PC_EXC;
        vector  = VEC_EXC;
        ri_flag = (code == EXC_RI);
        if (code >= EXC_INT0 && code <= EXC_INT7) begin
            vector = VEC_INT;
        end else if (code == EXC_ERET) begin
            pc_src = PC_ERET;
            vector = '0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / redirect controller for the 5-stage CPU.
// Produces per-register stall/flush vectors, PC source select and redirect
// vector. Exceptions arriving during a memory stall are held (PEND) and
// taken when the stall clears; load-use bubbles beyond the first are owed
// in the LU state.
// Optional feature: define HAZARD_WATCHDOG_EN to enable the stall watchdog.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      REG_AW      = 5,
    parameter int unsigned      LOAD_LAT    = 1,
    parameter logic [XLEN-1:0]  VEC_EXC     = 32'h80000000,
    parameter logic [XLEN-1:0]  VEC_INT     = 32'h80000180,
    parameter int unsigned      WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_jmp,
    input  logic              mem_jr,
    input  logic              mem_branch_state,
    input  logic              mem_stall,
    input  logic [31:0]       mem_excepttype,
    input  logic              idex_mem_r,
    input  logic [REG_AW-1:0] ifid_rs_addr,
    input  logic [REG_AW-1:0] ifid_real_rt_addr,
    input  logic [REG_AW-1:0] idex_real_rd_addr,
    output logic [4:0]        cu_stall,
    output logic [4:0]        cu_flush,
    output logic [2:0]        cu_pc_src,
    output logic [XLEN-1:0]   cu_vector,
    output logic              cu_exc_taken,
    output logic              cu_wdog_to
);

    hz_state_e   st, st_nxt;
    logic [31:0] exc_q, exc_q_nxt;
    logic [1:0]  lu_cnt, lu_cnt_nxt;

    logic            exc_live;
    logic            br_live;
    logic            lu_hit;
    logic            do_exc;
    logic            do_br;
    logic [31:0]     sel_code;
    logic [2:0]      map_src;
    logic [XLEN-1:0] map_vec;
    logic            map_ri;

    assign exc_live = (mem_excepttype != EXC_NONE);
    assign br_live  = mem_branch_state | mem_jr;
    assign lu_hit   = idex_mem_r &&
                      ((ifid_rs_addr == idex_real_rd_addr) ||
                       (ifid_real_rt_addr == idex_real_rd_addr));
    // A held exception redirects from the latched code, never the live input
    assign sel_code = (st == PEND) ? exc_q : mem_excepttype;

    exc_vector_map #(
        .XLEN    (XLEN),
        .VEC_EXC (VEC_EXC),
        .VEC_INT (VEC_INT)
    ) u_map (
        .code    (sel_code),
        .pc_src  (map_src),
        .vector  (map_vec),
        .ri_flag (map_ri)
    );

`ifdef HAZARD_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
    logic            wd_hit;

    // Timeout fires on the WDOG_CYCLES-th consecutive stalled cycle
    assign wd_hit = mem_stall && (wd_cnt == WD_W'(WDOG_CYCLES - 1));
`endif

    // Output decode and next-state selection from state and live inputs
    always_comb begin
        cu_stall     = SF_NONE;
        cu_flush     = SF_NONE;
        cu_pc_src    = PC_SEQ;
        cu_vector    = '0;
        cu_exc_taken = 1'b0;
        cu_wdog_to   = 1'b0;
        st_nxt       = st;
        exc_q_nxt    = exc_q;
        lu_cnt_nxt   = lu_cnt;
        do_exc       = 1'b0;
        do_br        = 1'b0;

        unique case (st)
            RUN: begin
                if (mem_stall) begin
                    cu_stall = STALL_ALL;
                    if (exc_live) begin
                        exc_q_nxt = mem_excepttype;
                        st_nxt    = PEND;
                    end
                end else if (exc_live) begin
                    do_exc = 1'b1;
                end else if (br_live) begin
                    do_br = 1'b1;
                end else if (id_jmp) begin
                    cu_pc_src = PC_JMP;
                end else if (lu_hit) begin
                    cu_stall = STALL_LU;
                    cu_flush = FLUSH_LU;
                    if (LOAD_LAT > 1) begin
                        lu_cnt_nxt = 2'(LOAD_LAT - 1);
                        st_nxt     = LU;
                    end
                end
            end
            PEND: begin
                if (mem_stall) begin
                    cu_stall = STALL_ALL;
                end else begin
                    do_exc    = 1'b1;
                    exc_q_nxt = EXC_NONE;
                    st_nxt    = RUN;
                end
            end
            LU: begin
                if (mem_stall) begin
                    // Bubbles are frozen; an exception still must not be lost
                    cu_stall = STALL_ALL;
                    if (exc_live) begin
                        exc_q_nxt  = mem_excepttype;
                        lu_cnt_nxt = 2'd0;
                        st_nxt     = PEND;
                    end
                end else if (exc_live) begin
                    do_exc     = 1'b1;
                    lu_cnt_nxt = 2'd0;
                    st_nxt     = RUN;
                end else if (br_live) begin
                    do_br      = 1'b1;
                    lu_cnt_nxt = 2'd0;
                    st_nxt     = RUN;
                end else begin
                    cu_stall   = STALL_LU;
                    cu_flush   = FLUSH_LU;
                    lu_cnt_nxt = lu_cnt - 2'd1;
                    if (lu_cnt == 2'd1) begin
                        st_nxt = RUN;
                    end
                end
            end
            default: begin
                st_nxt = RUN;
            end
        endcase

        if (do_exc) begin
            cu_flush     = FLUSH_EXC;
            cu_exc_taken = 1'b1;
            cu_pc_src    = map_src;
            cu_vector    = (map_src == PC_EXC) ? map_vec : '0;
            if (map_ri) begin
                cu_stall = SF_NONE;
            end
        end

        if (do_br) begin
            cu_pc_src = PC_CTRL;
            cu_flush  = FLUSH_BR;
        end

`ifdef HAZARD_WATCHDOG_EN
        wd_cnt_nxt = mem_stall ? (wd_cnt + 1'b1) : '0;
        if (wd_hit) begin
            cu_stall     = SF_NONE;
            cu_flush     = FLUSH_WDOG;
            cu_pc_src    = PC_EXC;
            cu_vector    = VEC_EXC;
            cu_wdog_to   = 1'b1;
            cu_exc_taken = 1'b1;
            wd_cnt_nxt   = '0;
            st_nxt       = RUN;
            exc_q_nxt    = EXC_NONE;
            lu_cnt_nxt   = 2'd0;
        end
`endif

        // While reset is held the pipeline registers are flushed
        if (reset) begin
            cu_stall     = SF_NONE;
            cu_flush     = FLUSH_EXC;
            cu_pc_src    = PC_SEQ;
            cu_vector    = '0;
            cu_exc_taken = 1'b0;
            cu_wdog_to   = 1'b0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= RUN;
            exc_q  <= EXC_NONE;
            lu_cnt <= 2'd0;
        end else begin
            st     <= st_nxt;
            exc_q  <= exc_q_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

`ifdef HAZARD_WATCHDOG_EN
    // Consecutive memory-stall cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_LAT 2 and 3)
// share one stimulus stream; expected values are hand-computed constants.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_jmp, mem_jr, mem_branch_state, mem_stall, idex_mem_r;
    logic [31:0] mem_excepttype;
    logic [4:0]  rs, rt, rd;

    logic [4:0]  a2_stall, a2_flush, a3_stall, a3_flush;
    logic [2:0]  a2_src, a3_src;
    logic [31:0] a2_vec, a3_vec;
    logic        a2_tk, a3_tk, a2_wd, a3_wd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(2), .WDOG_CYCLES(8)) u_lat2 (
        .clk(clk), .reset(reset), .id_jmp(id_jmp), .mem_jr(mem_jr),
        .mem_branch_state(mem_branch_state), .mem_stall(mem_stall),
        .mem_excepttype(mem_excepttype), .idex_mem_r(idex_mem_r),
        .ifid_rs_addr(rs), .ifid_real_rt_addr(rt), .idex_real_rd_addr(rd),
        .cu_stall(a2_stall), .cu_flush(a2_flush), .cu_pc_src(a2_src),
        .cu_vector(a2_vec), .cu_exc_taken(a2_tk), .cu_wdog_to(a2_wd)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .WDOG_CYCLES(8)) u_lat3 (
        .clk(clk), .reset(reset), .id_jmp(id_jmp), .mem_jr(mem_jr),
        .mem_branch_state(mem_branch_state), .mem_stall(mem_stall),
        .mem_excepttype(mem_excepttype), .idex_mem_r(idex_mem_r),
        .ifid_rs_addr(rs), .ifid_real_rt_addr(rt), .idex_real_rd_addr(rd),
        .cu_stall(a3_stall), .cu_flush(a3_flush), .cu_pc_src(a3_src),
        .cu_vector(a3_vec), .cu_exc_taken(a3_tk), .cu_wdog_to(a3_wd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs of one instance (which = 2 or 3)
    task automatic exp_o(input string tag, input int which, input logic [4:0] s,
                         input logic [4:0] f, input logic [2:0] p,
                         input logic [31:0] v, input logic tk, input logic wd);
        if (which == 2) begin
            chk({tag, "/l2.stall"}, 32'(a2_stall), 32'(s));
            chk({tag, "/l2.flush"}, 32'(a2_flush), 32'(f));
            chk({tag, "/l2.src"},   32'(a2_src),   32'(p));
            chk({tag, "/l2.vec"},   a2_vec,        v);
            chk({tag, "/l2.taken"}, 32'(a2_tk),    32'(tk));
            chk({tag, "/l2.wdog"},  32'(a2_wd),    32'(wd));
        end else begin
            chk({tag, "/l3.stall"}, 32'(a3_stall), 32'(s));
            chk({tag, "/l3.flush"}, 32'(a3_flush), 32'(f));
            chk({tag, "/l3.src"},   32'(a3_src),   32'(p));
            chk({tag, "/l3.vec"},   a3_vec,        v);
            chk({tag, "/l3.taken"}, 32'(a3_tk),    32'(tk));
            chk({tag, "/l3.wdog"},  32'(a3_wd),    32'(wd));
        end
    endtask

    task automatic both(input string tag, input logic [4:0] s, input logic [4:0] f,
                        input logic [2:0] p, input logic [31:0] v, input logic tk);
        exp_o(tag, 2, s, f, p, v, tk, 1'b0);
        exp_o(tag, 3, s, f, p, v, tk, 1'b0);
    endtask

    task automatic idle_in();
        id_jmp = 0; mem_jr = 0; mem_branch_state = 0; mem_stall = 0;
        idex_mem_r = 0; mem_excepttype = 0; rs = 0; rt = 0; rd = 0;
    endtask

    // Advance to just after the next active edge, then settle
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        #2;
        both("reset", 5'b00000, 5'b01110, 3'd4, 32'h0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        #3;
        both("idle", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Interrupt, RI and eret with no stall: same-cycle redirect
        cyc(); mem_excepttype = 32'h3; #3;
        both("int3", 5'b00000, 5'b01110, 3'd1, 32'h80000180, 1'b1);
        cyc(); mem_excepttype = 32'hA; #3;
        both("ri", 5'b00000, 5'b01110, 3'd1, 32'h80000000, 1'b1);
        cyc(); mem_excepttype = 32'hD; #3;
        both("eret", 5'b00000, 5'b01110, 3'd2, 32'h0, 1'b1);
        cyc(); mem_excepttype = 32'h5; mem_branch_state = 1; #3;
        both("exc_over_br", 5'b00000, 5'b01110, 3'd1, 32'h80000180, 1'b1);

        // Branch, jr, jump
        cyc(); mem_excepttype = 0; #3;
        both("branch", 5'b00000, 5'b00110, 3'd3, 32'h0, 1'b0);
        cyc(); mem_branch_state = 0; mem_jr = 1; id_jmp = 1; #3;
        both("jr", 5'b00000, 5'b00110, 3'd3, 32'h0, 1'b0);
        cyc(); mem_jr = 0; #3;
        both("jmp", 5'b00000, 5'b00000, 3'd0, 32'h0, 1'b0);

        // Exception behind a 4-cycle stall, taken from the latched code
        cyc(); id_jmp = 0; mem_stall = 1; mem_excepttype = 32'hB; #3;
        both("pend1", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); mem_excepttype = 0; #3;
        both("pend2", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); #3;
        both("pend3", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); #3;
        both("pend4", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); mem_stall = 0; #3;
        both("pend_take", 5'b00000, 5'b01110, 3'd1, 32'h80000000, 1'b1);
        cyc(); #3;
        both("pend_after", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Load-use misses: no load, or no register match
        cyc(); idex_mem_r = 0; rs = 5; rd = 5; #3;
        both("lu_noload", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); idex_mem_r = 1; rs = 1; rt = 2; rd = 3; #3;
        both("lu_nomatch", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Load-use on rs: 2 bubbles for LOAD_LAT=2, 3 for LOAD_LAT=3
        cyc(); rs = 5; rt = 0; rd = 5; #3;
        both("lu_b1", 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0);
        cyc(); idex_mem_r = 0; rs = 0; rd = 0; #3;
        both("lu_b2", 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0);
        cyc(); #3;
        exp_o("lu_b3", 2, 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0, 1'b0);
        exp_o("lu_b3", 3, 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0, 1'b0);
        cyc(); #3;
        both("lu_done", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Load-use on rt, branch in the 2nd bubble ends LU
        cyc(); idex_mem_r = 1; rs = 1; rt = 7; rd = 7; #3;
        both("lubr_b1", 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0);
        cyc(); idex_mem_r = 0; rt = 0; rd = 0; mem_branch_state = 1; #3;
        both("lubr_br", 5'b00000, 5'b00110, 3'd3, 32'h0, 1'b0);
        cyc(); mem_branch_state = 0; #3;
        both("lubr_run", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // mem_stall during LU freezes the bubble count
        cyc(); idex_mem_r = 1; rs = 4; rd = 4; #3;
        both("lust_b1", 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0);
        cyc(); idex_mem_r = 0; rs = 0; rd = 0; mem_stall = 1; #3;
        both("lust_st", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); mem_stall = 0; #3;
        both("lust_b2", 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0);
        cyc(); #3;
        exp_o("lust_b3", 2, 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0, 1'b0);
        exp_o("lust_b3", 3, 5'b00011, 5'b00100, 3'd4, 32'h0, 1'b0, 1'b0);
        cyc(); #3;
        both("lust_done", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Long stall: watchdog fires on the 8th cycle when compiled in
`ifdef HAZARD_WATCHDOG_EN
        for (int i = 1; i <= 7; i++) begin
            cyc(); mem_stall = 1; #3;
            both("wd_wait", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        end
        cyc(); #3;
        exp_o("wd_fire", 2, 5'b00000, 5'b11110, 3'd1, 32'h80000000, 1'b1, 1'b1);
        exp_o("wd_fire", 3, 5'b00000, 5'b11110, 3'd1, 32'h80000000, 1'b1, 1'b1);
        cyc(); #3;
        both("wd_after", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
`else
        for (int i = 1; i <= 10; i++) begin
            cyc(); mem_stall = 1; #3;
            both("long_stall", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        end
`endif
        cyc(); mem_stall = 0; #3;
        both("stall_end", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        // Async reset while PEND abandons the held exception
        cyc(); mem_stall = 1; mem_excepttype = 32'h9; #3;
        both("rpend1", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); mem_excepttype = 0; #3;
        both("rpend2", 5'b11111, 5'b00000, 3'd4, 32'h0, 1'b0);
        reset = 1'b1; mem_stall = 0; #1;
        both("rpend_rst", 5'b00000, 5'b01110, 3'd4, 32'h0, 1'b0);
        cyc(); reset = 1'b0; #3;
        both("rpend_rel", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);
        cyc(); #3;
        both("rpend_quiet", 5'b00000, 5'b00000, 3'd4, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
